fetch_predecode_queue: RTL
==========================

Name: fetch_predecode_queue

Overview:
- Parametrised byte-stream prefetch queue and instruction assembler that sits between the memory read port and the opcode decoder.
- Buffers fetched bytes and determines each instruction's length (1-3 bytes) from its opcode.
- Presents complete instructions (opcode, operand, length, PC) through a valid/ready handshake.
- Supports a flush with a new PC on taken branches, jumps and interrupts.

Parameters:
- DEPTH, 8, byte capacity of the queue; power of 2, minimum 4 (elaboration-time assertion).
- RESET_PC, 16'h0000, value loaded into the instruction PC on reset.
- BRK_LEN, 1, length reported for opcode 8'h00 (1 or 2).
- LW, $clog2(DEPTH+1), width of the level output.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- flush  in  1  discard queue contents and reload PC
- flush_pc  in  16  new PC applied on flush
- in_valid  in  1  in_data holds a fetched byte
- in_data  in  8  fetched byte
- in_ready  out  1  queue accepts a byte this cycle
- out_valid  out  1  a complete instruction is at the head
- out_ready  in  1  consumer takes the head instruction
- out_opcode  out  8  head opcode byte
- out_operand  out  16  {hi,lo} operand; unused bytes are 0
- out_len  out  2  instruction length, 1..3
- out_pc  out  16  address of the head opcode
- level  out  LW  bytes currently held

Behaviour:
- Storage: circular buffer DEPTH x 8 with read pointer, write pointer and count register. Pointers wrap modulo DEPTH.
- Reset values:
  - count = 0, pointers = 0, pc = RESET_PC.
  - Outputs: out_valid = 0, in_ready = 1, level = 0, out_len = 1, out_opcode = 0, out_operand = 0.
- Push: when in_valid && in_ready, in_data is written at the write pointer and the pointer advances.
- Ready: in_ready = (count < DEPTH). It is combinational from registered count and does not depend on out_ready.
- Length rule, evaluated on the head byte h = {aaa,bbb,cc}:
  - len = BRK_LEN if h == 8'h00.
  - len = 1 if h is 8'h40 or 8'h60, or matches ???_?10_?0.
  - len = 3 if h == 8'h20, or bbb == 011, or bbb == 111, or (bbb == 110 and cc[0] == 1).
  - len = 2 otherwise.
- Output validity: out_valid = (count >= len) && (count != 0). It is combinational from registered state only.
- Latency: a byte pushed in cycle N is visible in the head view in cycle N+1. A 1-byte instruction whose opcode is pushed in cycle N has out_valid = 1 in cycle N+1.
- Head fields:
  - out_opcode = buf[rp].
  - out_operand[7:0] = buf[rp+1] if len >= 2, else 0.
  - out_operand[15:8] = buf[rp+2] if len == 3, else 0.
  - Indices wrap modulo DEPTH.
- Pop: when out_valid && out_ready, rp += len and pc += len. pc wraps modulo 2^16 (FFFF + 1 -> 0000).
- Simultaneous push and pop: count_next = count + 1 - len. The push always writes the slot beyond the current tail, so no overlap with popped slots.
- Full: count == DEPTH gives in_ready = 0. A pop in the same cycle does not raise in_ready until the next cycle.
- Partial instruction: count < len holds out_valid = 0 and state is unchanged until more bytes arrive.
- Flush has highest priority:
  - Sets count = 0, rp = wp = 0, pc = flush_pc.
  - Any push or pop attempted in the flush cycle is ignored. in_data is dropped even if in_valid && in_ready.
  - out_valid may be high during the flush cycle from old state, but the consumer must not treat it as consumed.
  - The cycle after a flush: out_valid = 0, level = 0, out_pc = flush_pc.
- Reset mid-operation: asynchronous return to the reset values above. Buffer contents need not be cleared, because count = 0 masks them.
- level = count.

Test Plan:
- Reset, then push A9 05 8D 00 02 EA (one byte per cycle, out_ready = 0):
  - after 2 bytes: out_valid = 1, len = 2, opcode A9, operand 0005, pc = RESET_PC.
  - with all 6 bytes held: level = 6.
- Continue the first scenario with out_ready = 1, one pop per cycle:
  - pops A9/0005 at pc 0000, then 8D/0200 (len 3) at pc 0002, then EA (len 1, operand 0000) at pc 0005.
  - level = 0 afterwards.
- Fill DEPTH = 8 with 8 bytes: in_ready = 0. Push attempt with in_valid = 1 is not accepted. Pop a 3-byte instruction: level = 5, in_ready = 1 the next cycle. Next 3-byte instruction straddling the wrap point is assembled correctly.
- Push 4C 34 only (a 3-byte opcode): out_valid stays 0. Push 12: out_valid = 1, operand 1234. Push and pop in the same cycle: level = 3 + 1 - 3 = 1.
- Flush with flush_pc = 8000 while holding 5 bytes and pushing in the same cycle: next cycle level = 0, out_valid = 0, out_pc = 8000, and the flush-cycle byte is absent.
- pc wrap: RESET_PC = FFFE, push EA EA EA and pop all three: out_pc goes FFFE, FFFF, 0000. Assert rst mid-stream: all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_predecode_queue.sv
// fetch_predecode_queue: byte prefetch queue that assembles 1-3 byte
// instructions from a fetched byte stream and hands them to the decoder
// together with their PC. A flush drops all held bytes and reloads the PC.
//
// Handshakes (both sides): a transfer happens in a cycle where valid and
// ready are both high at the rising clock edge. in_ready is derived only from
// the registered byte count. out_valid is derived only from registered state.
// Neither ready depends on the other side's valid, and during a flush cycle
// no transfer takes effect on either side.
module fetch_predecode_queue #(
  parameter int          DEPTH    = 8,
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          BRK_LEN  = 1,
  parameter int          LW       = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [15:0]   flush_pc,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_opcode,
  output logic [15:0]   out_operand,
  output logic [1:0]    out_len,
  output logic [15:0]   out_pc,
  output logic [LW-1:0] level
);

  localparam int         PW        = $clog2(DEPTH);
  localparam logic [1:0] BRK_LEN_L = 2'(BRK_LEN);

  if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fetch_predecode_queue: DEPTH must be a power of 2 and at least 4");
  end
  if (BRK_LEN < 1 || BRK_LEN > 2) begin : g_bad_brk
    $error("fetch_predecode_queue: BRK_LEN must be 1 or 2");
  end

  logic [7:0]    r_mem [DEPTH];
  logic [PW-1:0] r_rp;
  logic [PW-1:0] r_wp;
  logic [LW-1:0] r_count;
  logic [15:0]   r_pc;

  logic [PW-1:0] w_rp1;
  logic [PW-1:0] w_rp2;
  logic [7:0]    w_head;
  logic [1:0]    w_raw_len;
  logic [1:0]    w_len;
  logic [LW-1:0] w_len_ext;
  logic [LW-1:0] w_count_next;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;

  // Operand slots follow the head and wrap naturally with the pointer width
  assign w_rp1   = r_rp + PW'(1);
  assign w_rp2   = r_rp + PW'(2);
  assign w_head  = r_mem[r_rp];
  assign w_empty = (r_count == {LW{1'b0}});

  // Instruction length from the head opcode h = {aaa,bbb,cc}
  always_comb begin
    w_raw_len = 2'd2;
    if (w_head == 8'h00) begin
      w_raw_len = BRK_LEN_L;
    end else if (w_head == 8'h40 || w_head == 8'h60 ||
                 (w_head[3:2] == 2'b10 && !w_head[0])) begin
      w_raw_len = 2'd1;
    end else if (w_head == 8'h20 || w_head[4:2] == 3'b011 || w_head[4:2] == 3'b111 ||
                 (w_head[4:2] == 3'b110 && w_head[0])) begin
      w_raw_len = 2'd3;
    end
  end

  // An empty queue presents a neutral head (len 1, zero opcode/operand)
  assign w_len     = w_empty ? 2'd1 : w_raw_len;
  assign w_len_ext = LW'(w_len);

  assign in_ready  = (r_count < LW'(DEPTH));
  assign out_valid = !w_empty && (r_count >= w_len_ext);

  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = out_valid && out_ready && !flush;

  assign out_opcode        = w_empty ? 8'h00 : w_head;
  assign out_operand[7:0]  = (!w_empty && w_len >= 2'd2) ? r_mem[w_rp1] : 8'h00;
  assign out_operand[15:8] = (!w_empty && w_len == 2'd3) ? r_mem[w_rp2] : 8'h00;
  assign out_len           = w_len;
  assign out_pc            = r_pc;
  assign level             = r_count;

  // A push lands beyond the tail, so it never collides with popped slots
  assign w_count_next = r_count
                      + (w_push ? LW'(1) : {LW{1'b0}})
                      - (w_pop ? w_len_ext : {LW{1'b0}});

  // Pointer, count and PC state; flush overrides any push or pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
      r_pc    <= RESET_PC;
    end else if (flush) begin
      r_rp    <= '0;
      r_wp    <= '0;
      r_count <= '0;
      r_pc    <= flush_pc;
    end else begin
      if (w_push) begin
        r_wp <= r_wp + PW'(1);
      end
      if (w_pop) begin
        r_rp <= r_rp + PW'(w_len);
        r_pc <= r_pc + 16'(w_len);
      end
      r_count <= w_count_next;
    end
  end

  // Byte storage; stale contents are masked by the count
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wp] <= in_data;
    end
  end

endmodule
